// File: rtl/walking_one_pkg.sv
// Shared constants and encodings for the walking-one sequencer.
package walking_one_pkg;

    localparam logic [1:0] MODE_UP       = 2'd0;
    localparam logic [1:0] MODE_DOWN     = 2'd1;
    localparam logic [1:0] MODE_PINGPONG = 2'd2;
    localparam logic [1:0] MODE_ROTATE   = 2'd3;

    typedef enum logic {ST_IDLE, ST_RUN} state_e;
    typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

    function automatic logic is_oneshot(input logic [1:0] mode);
        return (mode == MODE_UP) || (mode == MODE_DOWN);
    endfunction

endpackage

// File: rtl/walking_one_seq_if.sv
// Control/pattern bus of the walking-one sequencer; err_onehot exists only
// when WALK_ONEHOT_CHECK_EN is defined.
interface walking_one_seq_if #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned IDX_W = $clog2(WIDTH)
);
    logic             start;
    logic             stop;
    logic [1:0]       mode;
    logic [WIDTH-1:0] pattern;
    logic             valid;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] step_idx;
`ifdef WALK_ONEHOT_CHECK_EN
    logic             err_onehot;

    modport master (
        input  start, stop, mode,
        output pattern, valid, busy, done, step_idx, err_onehot
    );
    modport slave (
        output start, stop, mode,
        input  pattern, valid, busy, done, step_idx, err_onehot
    );
`else
    modport master (
        input  start, stop, mode,
        output pattern, valid, busy, done, step_idx
    );
    modport slave (
        output start, stop, mode,
        input  pattern, valid, busy, done, step_idx
    );
`endif
endinterface

// File: rtl/walk_hold_timer.sv
// Counts HOLD_CYCLES cycles per step; tick is high in the last hold cycle.
module walk_hold_timer #(
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int unsigned CntW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(HOLD_CYCLES - 1);

    logic [CntW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (r_cnt == LastCnt) ? '0 : r_cnt + 1'b1;
        end
    end

    assign tick = en && (r_cnt == LastCnt);
endmodule

// File: rtl/walking_one_seq.sv
// Walking-one pattern generator: UP/DOWN one-shot, PINGPONG/ROTATE continuous.
// Define WALK_ONEHOT_CHECK_EN to add the sticky err_onehot self-check.
module walking_one_seq
    import walking_one_pkg::*;
#(
    parameter int unsigned WIDTH       = 6,
    parameter int unsigned HOLD_CYCLES = 1,
    parameter int unsigned IDX_W       = $clog2(WIDTH)
) (
    input logic               clk,
    input logic               rst,
    walking_one_seq_if.master bus
);
    if (WIDTH < 2) begin : g_bad_width
        $error("walking_one_seq: WIDTH must be at least 2");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("walking_one_seq: HOLD_CYCLES must be at least 1");
    end

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(WIDTH - 1);

    state_e           r_state, w_state_next;
    dir_e             r_dir, w_dir_next;
    logic [1:0]       r_mode, w_mode_next;
    logic [IDX_W-1:0] r_idx, w_idx_next;
    logic [WIDTH-1:0] r_pattern, w_pattern_next;
    logic             r_valid, w_valid_next;
    logic             r_busy, w_busy_next;
    logic             r_done, w_done_next;
    logic             w_tick, w_at_end, w_finish;

    walk_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (r_state == ST_IDLE),
        .en   (r_state == ST_RUN),
        .tick (w_tick)
    );

    always_comb begin
        w_state_next = r_state;
        w_dir_next   = r_dir;
        w_mode_next  = r_mode;
        w_idx_next   = r_idx;
        w_valid_next = r_valid;
        w_busy_next  = r_busy;
        w_done_next  = 1'b0;
        w_finish     = 1'b0;
        w_at_end     = (r_dir == DIR_UP) ? (r_idx == LastIdx) : (r_idx == '0);

        unique case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_next = ST_RUN;
                    w_mode_next  = bus.mode;
                    w_valid_next = 1'b1;
                    w_busy_next  = 1'b1;
                    w_dir_next   = (bus.mode == MODE_DOWN) ? DIR_DOWN : DIR_UP;
                    w_idx_next   = (bus.mode == MODE_DOWN) ? LastIdx : '0;
                end
            end
            ST_RUN: begin
                if (bus.stop) begin
                    w_state_next = ST_IDLE;
                    w_valid_next = 1'b0;
                    w_busy_next  = 1'b0;
                    w_dir_next   = DIR_UP;
                    w_idx_next   = '0;
                end else if (w_tick) begin
                    if (r_mode == MODE_ROTATE) begin
                        w_idx_next = w_at_end ? '0 : r_idx + 1'b1;
                    end else if (w_at_end && is_oneshot(r_mode)) begin
                        w_finish = 1'b1;
                    end else begin
                        // Reverse at an end bit so that bit is shown only once.
                        if (w_at_end) begin
                            w_dir_next = (r_dir == DIR_UP) ? DIR_DOWN : DIR_UP;
                        end
                        w_idx_next = (w_dir_next == DIR_UP) ? r_idx + 1'b1 : r_idx - 1'b1;
                    end
                end
                if (w_finish) begin
                    w_state_next = ST_IDLE;
                    w_valid_next = 1'b0;
                    w_busy_next  = 1'b0;
                    w_done_next  = 1'b1;
                    w_dir_next   = DIR_UP;
                    w_idx_next   = '0;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        w_pattern_next = w_valid_next ? (WIDTH'(1) << w_idx_next) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_dir     <= DIR_UP;
            r_mode    <= MODE_UP;
            r_idx     <= '0;
            r_pattern <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_dir     <= w_dir_next;
            r_mode    <= w_mode_next;
            r_idx     <= w_idx_next;
            r_pattern <= w_pattern_next;
            r_valid   <= w_valid_next;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
        end
    end

    assign bus.pattern  = r_pattern;
    assign bus.valid    = r_valid;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.step_idx = r_idx;

`ifdef WALK_ONEHOT_CHECK_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (r_valid && (!$onehot(r_pattern) || (r_pattern != (WIDTH'(1) << r_idx)))) begin
            r_err <= 1'b1;
        end
    end

    assign bus.err_onehot = r_err;
`endif
endmodule
